// File: rtl/seven_seg_pkg.sv
// Shared types, glyph table and decode helpers for the seven-segment receive path.
// Declarations only; no timing or flow control of its own.
package seven_seg_pkg;

  localparam logic [6:0] BLANK = 7'b1111111;

  // Active-low gfedcba patterns; the first entry below is index 15 (F), the last is index 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110,
    7'b0000110,
    7'b0100001,
    7'b1000110,
    7'b0000011,
    7'b0001000,
    7'b0011000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } sample_t;

  localparam sample_t BLANK_SAMPLE = '{an: 4'hF, seg: BLANK, dp: 1'b1};

  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH_TABLE[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] an);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~an[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational 7-segment pattern to hex nibble lookup; hit=0 when the pattern is not a hex glyph.
// Zero latency, no flow control.
module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  assign {hit, nibble} = glyph_decode(seg);

endmodule

// File: rtl/seven_seg_decoder.sv
// Rebuilds a 4-digit hex value from multiplexed active-low strobes; outputs follow input by STABLE_CYCLES+1 clks.
// No backpressure: every sample is consumed. SEVEN_SEG_DECODER_DP_EN adds dp_in/dp_out.
module seven_seg_decoder
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AGE_W          = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  an_in,
  input  logic [6:0]  seg_in,
`ifdef SEVEN_SEG_DECODER_DP_EN
  input  logic        dp_in,
  output logic [3:0]  dp_out,
`endif
  output logic [15:0] digits_out,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_err,
  output logic        frame_done,
  output logic        an_illegal
);

  localparam int RUN_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(STABLE_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT_CYCLES);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 1);

  sample_t              in_smp;
  sample_t              s_smp;
  sample_t              prev_smp;
  state_t               state;
  state_t               state_nxt;
  logic [RUN_W-1:0]     run;
  logic [RUN_W-1:0]     run_nxt;
  logic                 cap;
  logic                 restart;
  logic                 legal;
  logic                 same;
  logic [2:0]           lows;
  logic [3:0]           cap_oh;
  logic [3:0]           mask;
  logic [3:0]           mask_all;
  logic                 hit;
  logic [3:0]           nib;
  logic [3:0][AGE_W-1:0] age;
  logic                 dp_raw;

`ifdef SEVEN_SEG_DECODER_DP_EN
  assign dp_raw = dp_in;
`else
  assign dp_raw = 1'b1;
`endif

  assign in_smp = {an_in, seg_in, dp_raw};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_smp    <= BLANK_SAMPLE;
      prev_smp <= BLANK_SAMPLE;
      state    <= WAIT;
      run      <= '0;
    end else begin
      s_smp    <= in_smp;
      prev_smp <= s_smp;
      state    <= state_nxt;
      run      <= run_nxt;
    end
  end

  assign lows  = low_count(s_smp.an);
  assign legal = (lows == 3'd1);
  assign same  = (s_smp == prev_smp);

  // A run counts consecutive identical legal samples; capture fires once, when it reaches STABLE_CYCLES.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    cap       = 1'b0;
    restart   = 1'b0;
    case (state)
      WAIT: begin
        restart = legal;
      end
      COUNT: begin
        if (!legal) begin
          state_nxt = WAIT;
          run_nxt   = '0;
        end else if (!same) begin
          restart = 1'b1;
        end else if (run == RUN_LAST) begin
          run_nxt   = RUN_FULL;
          cap       = 1'b1;
          state_nxt = HELD;
        end else begin
          run_nxt = run + RUN_W'(1);
        end
      end
      HELD: begin
        if (!legal) begin
          state_nxt = WAIT;
          run_nxt   = '0;
        end else begin
          restart = !same;
        end
      end
      default: begin
        state_nxt = WAIT;
        run_nxt   = '0;
      end
    endcase
    if (restart) begin
      run_nxt = RUN_W'(1);
      if (STABLE_CYCLES <= 1) begin
        cap       = 1'b1;
        state_nxt = HELD;
      end else begin
        state_nxt = COUNT;
      end
    end
  end

  seven_seg_glyph_decode u_glyph (
    .seg    (s_smp.seg),
    .hit    (hit),
    .nibble (nib)
  );

  assign cap_oh   = cap ? ~s_smp.an : 4'b0000;
  assign mask_all = mask | cap_oh;

  // Timeout clears valid only; a capture on the timeout edge takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_out  <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      age         <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cap_oh[i]) begin
          if (hit) begin
            digits_out[4*i +: 4] <= nib;
            digit_valid[i]       <= 1'b1;
            digit_err[i]         <= 1'b0;
          end else begin
            digit_valid[i] <= 1'b0;
            digit_err[i]   <= 1'b1;
          end
          age[i] <= '0;
        end else if (age[i] != AGE_MAX) begin
          age[i] <= age[i] + AGE_W'(1);
          if (age[i] == AGE_LAST) digit_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask       <= '0;
      frame_done <= 1'b0;
      an_illegal <= 1'b0;
    end else begin
      an_illegal <= (lows > 3'd1);
      if (cap && (mask_all == 4'hF)) begin
        frame_done <= 1'b1;
        mask       <= '0;
      end else begin
        frame_done <= 1'b0;
        mask       <= mask_all;
      end
    end
  end

`ifdef SEVEN_SEG_DECODER_DP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_out <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cap_oh[i]) dp_out[i] <= ~s_smp.dp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Testbench for seven_seg_decoder with two instances (STABLE_CYCLES 1 and 3); DP ports follow SEVEN_SEG_DECODER_DP_EN.
`timescale 1ns/1ps
module tb_seven_seg_decoder;

  localparam int TMO = 1024;

  logic        clk;
  logic        reset_n;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] dig [2];
  logic [3:0]  vld [2];
  logic [3:0]  err [2];
  logic        fd  [2];
  logic        ill [2];
`ifdef SEVEN_SEG_DECODER_DP_EN
  logic        dp_in;
  logic [3:0]  dpo [2];
`endif

  seven_seg_decoder #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(TMO), .AGE_W(11)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .an_in(an_in), .seg_in(seg_in),
`ifdef SEVEN_SEG_DECODER_DP_EN
    .dp_in(dp_in), .dp_out(dpo[0]),
`endif
    .digits_out(dig[0]), .digit_valid(vld[0]), .digit_err(err[0]),
    .frame_done(fd[0]), .an_illegal(ill[0])
  );

  seven_seg_decoder #(.STABLE_CYCLES(3), .TIMEOUT_CYCLES(TMO), .AGE_W(11)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .an_in(an_in), .seg_in(seg_in),
`ifdef SEVEN_SEG_DECODER_DP_EN
    .dp_in(dp_in), .dp_out(dpo[1]),
`endif
    .digits_out(dig[1]), .digit_valid(vld[1]), .digit_err(err[1]),
    .frame_done(fd[1]), .an_illegal(ill[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic chk_model = 1'b0;
  logic [6:0] glyph [16];

  // reference model state
  logic [3:0]  m_an, l_an;
  logic [6:0]  m_seg, l_seg;
  logic        m_dp, l_dp;
  int          run;
  int          cyc;
  logic [15:0] e_dig [2];
  logic [3:0]  e_err [2];
  logic [3:0]  e_hit [2];
  logic [3:0]  e_dpo [2];
  int          e_capc [2][4];
  logic [3:0]  e_mask [2];
  logic        e_fd [2];
  logic        e_ill;

  typedef struct packed {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] dig;
    logic [3:0]  vld;
    logic        fd;
  } vec_t;
  vec_t tbl [10];

  function automatic vec_t mk(logic [3:0] an, logic [6:0] seg, logic [15:0] d, logic [3:0] v, logic f);
    vec_t x;
    x.an = an; x.seg = seg; x.dig = d; x.vld = v; x.fd = f;
    return x;
  endfunction

  function automatic int stab(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    l_an = 4'hF; l_seg = 7'h7F; l_dp = 1'b1;
    run = 0; cyc = 0; e_ill = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e_dig[k] = '0; e_err[k] = '0; e_hit[k] = '0; e_dpo[k] = '0;
      e_mask[k] = '0; e_fd[k] = 1'b0;
      for (int i = 0; i < 4; i++) e_capc[k][i] = 0;
    end
  endtask

  function automatic logic [3:0] exp_valid(int k);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = e_hit[k][i] && ((cyc - e_capc[k][i]) < TMO);
    return v;
  endfunction

  task automatic model_edge();
    int nl, idx, nibv;
    logic hitv;
    nl = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (!m_an[i]) begin nl++; idx = i; end
    e_ill = (nl >= 2);
    if (nl == 1) begin
      if (run > 0 && m_an == l_an && m_seg == l_seg && m_dp == l_dp) run++;
      else run = 1;
    end else begin
      run = 0;
    end
    l_an = m_an; l_seg = m_seg; l_dp = m_dp;
    cyc++;
    hitv = 1'b0; nibv = 0;
    for (int g = 0; g < 16; g++) if (glyph[g] == m_seg) begin hitv = 1'b1; nibv = g; end
    for (int k = 0; k < 2; k++) begin
      e_fd[k] = 1'b0;
      if (nl == 1 && run == stab(k)) begin
        if (hitv) e_dig[k][4*idx +: 4] = 4'(nibv);
        e_hit[k][idx] = hitv;
        e_err[k][idx] = !hitv;
        e_dpo[k][idx] = ~m_dp;
        e_capc[k][idx] = cyc;
        e_mask[k][idx] = 1'b1;
        if (e_mask[k] == 4'hF) begin e_fd[k] = 1'b1; e_mask[k] = '0; end
      end
    end
    m_an = an_in; m_seg = seg_in;
`ifdef SEVEN_SEG_DECODER_DP_EN
    m_dp = dp_in;
`endif
  endtask

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rand dig[%0d]", k), 32'(dig[k]), 32'(e_dig[k]));
      check($sformatf("rand valid[%0d]", k), 32'(vld[k]), 32'(exp_valid(k)));
      check($sformatf("rand err[%0d]", k), 32'(err[k]), 32'(e_err[k]));
      check($sformatf("rand frame_done[%0d]", k), 32'(fd[k]), 32'(e_fd[k]));
      check($sformatf("rand an_illegal[%0d]", k), 32'(ill[k]), 32'(e_ill));
`ifdef SEVEN_SEG_DECODER_DP_EN
      check($sformatf("rand dp_out[%0d]", k), 32'(dpo[k]), 32'(e_dpo[k]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (chk_model) compare_model();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s reset dig[%0d]", tag, k), 32'(dig[k]), 32'h0);
      check($sformatf("%s reset valid[%0d]", tag, k), 32'(vld[k]), 32'h0);
      check($sformatf("%s reset err[%0d]", tag, k), 32'(err[k]), 32'h0);
      check($sformatf("%s reset fd/ill[%0d]", tag, k), {30'd0, fd[k], ill[k]}, 32'h0);
`ifdef SEVEN_SEG_DECODER_DP_EN
      check($sformatf("%s reset dp_out[%0d]", tag, k), 32'(dpo[k]), 32'h0);
`endif
    end
    an_in = 4'hF; seg_in = 7'h7F;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    an_in = an; seg_in = seg;
  endtask

  initial begin
    reset_n = 1'b1;
    an_in = 4'hF; seg_in = 7'h7F;
`ifdef SEVEN_SEG_DECODER_DP_EN
    dp_in = 1'b1;
`endif
    glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100; glyph[3] = 7'b0110000;
    glyph[4] = 7'b0011001; glyph[5] = 7'b0010010; glyph[6] = 7'b0000010; glyph[7] = 7'b1111000;
    glyph[8] = 7'b0000000; glyph[9] = 7'b0011000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
    model_reset();

    // driver loop, expectations lag the inputs by one registered stage
    tbl[0] = mk(4'hE, glyph[5],  16'h0000, 4'b0000, 1'b0);
    tbl[1] = mk(4'hD, glyph[10], 16'h0005, 4'b0001, 1'b0);
    tbl[2] = mk(4'hB, glyph[0],  16'h00A5, 4'b0011, 1'b0);
    tbl[3] = mk(4'h7, glyph[0],  16'h00A5, 4'b0111, 1'b0);
    tbl[4] = mk(4'hE, glyph[5],  16'h00A5, 4'b1111, 1'b1);
    tbl[5] = mk(4'hD, glyph[10], 16'h00A5, 4'b1111, 1'b0);
    tbl[6] = mk(4'hB, glyph[0],  16'h00A5, 4'b1111, 1'b0);
    tbl[7] = mk(4'h7, glyph[0],  16'h00A5, 4'b1111, 1'b0);
    tbl[8] = mk(4'hE, glyph[5],  16'h00A5, 4'b1111, 1'b1);
    tbl[9] = mk(4'hF, 7'h7F,     16'h00A5, 4'b1111, 1'b0);

    do_reset("init");
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].an, tbl[i].seg);
      step();
      check($sformatf("loop%0d dig", i), 32'(dig[0]), 32'(tbl[i].dig));
      check($sformatf("loop%0d valid", i), 32'(vld[0]), 32'(tbl[i].vld));
      check($sformatf("loop%0d frame_done", i), 32'(fd[0]), 32'(tbl[i].fd));
      check($sformatf("loop%0d s3 valid", i), 32'(vld[1]), 32'h0);
    end

    // STABLE_CYCLES=3: two-clk hold does not capture, three-clk hold does
    do_reset("stable");
    drive(4'hD, glyph[6]); step(); step();
    drive(4'hF, 7'h7F); step(); step(); step();
    check("s3 short hold valid", 32'(vld[1]), 32'h0);
    check("s3 short hold dig", 32'(dig[1]), 32'h0);
    drive(4'hD, glyph[6]); step(); step(); step();
    drive(4'hF, 7'h7F);
    check("s3 before capture dig", 32'(dig[1]), 32'h0);
    step();
    check("s3 capture dig", 32'(dig[1]), 32'h0060);
    check("s3 capture valid", 32'(vld[1]), 32'b0010);

    // illegal glyph keeps the nibble
    do_reset("glyph");
    drive(4'hB, glyph[9]); step();
    drive(4'hB, 7'h7F); step();
    check("legal d2 dig", 32'(dig[0]), 32'h0900);
    check("legal d2 valid", 32'(vld[0]), 32'b0100);
    drive(4'hF, 7'h7F); step();
    check("bad glyph err", 32'(err[0]), 32'b0100);
    check("bad glyph valid", 32'(vld[0]), 32'b0000);
    check("bad glyph dig kept", 32'(dig[0]), 32'h0900);

    // two anodes low for one clk
    drive(4'hC, glyph[1]); step();
    drive(4'hF, 7'h7F);
    check("an_illegal before", 32'(ill[0]), 32'h0);
    step();
    check("an_illegal pulse s1", 32'(ill[0]), 32'h1);
    check("an_illegal pulse s3", 32'(ill[1]), 32'h1);
    check("an_illegal no capture", {24'd0, vld[0], err[0]}, {24'd0, 4'b0000, 4'b0100});
    step();
    check("an_illegal cleared", 32'(ill[0]), 32'h0);

    // staleness timeout
    do_reset("timeout");
    drive(4'hE, glyph[3]); step();
    drive(4'hF, 7'h7F); step();
    check("timeout capture valid", 32'(vld[0]), 32'b0001);
    repeat (TMO - 1) step();
    check("timeout last valid clk", 32'(vld[0]), 32'b0001);
    step();
    check("timeout valid cleared", 32'(vld[0]), 32'b0000);
    check("timeout dig retained", 32'(dig[0]), 32'h0003);

    // reset after three digits, then a fresh frame
    do_reset("preframe");
    drive(4'hE, glyph[1]); step();
    drive(4'hD, glyph[2]); step();
    drive(4'hB, glyph[3]); step();
    drive(4'hF, 7'h7F); step();
    check("three digits valid", 32'(vld[0]), 32'b0111);
    check("three digits dig", 32'(dig[0]), 32'h0321);
    check("three digits no frame", 32'(fd[0]), 32'h0);
    do_reset("midframe");
    drive(4'hE, glyph[4]); step();
    drive(4'hD, glyph[5]); step();
    check("refill d0 no frame", 32'(fd[0]), 32'h0);
    drive(4'hB, glyph[6]); step();
    check("refill d1 no frame", 32'(fd[0]), 32'h0);
    drive(4'h7, glyph[7]); step();
    check("refill d2 no frame", 32'(fd[0]), 32'h0);
    drive(4'hF, 7'h7F); step();
    check("refill d3 frame", 32'(fd[0]), 32'h1);
    check("refill dig", 32'(dig[0]), 32'h7654);

    // randomized bursts against the reference model
    do_reset("random");
    chk_model = 1'b1;
    for (int b = 0; b < 500; b++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) an_in = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
      else if (r == 7) an_in = 4'hF;
      else an_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) seg_in = glyph[$urandom_range(0, 15)];
      else seg_in = 7'($urandom_range(0, 127));
`ifdef SEVEN_SEG_DECODER_DP_EN
      dp_in = 1'($urandom_range(0, 1));
`endif
      repeat ($urandom_range(1, 6)) step();
    end
    chk_model = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
